// File: rtl/shift_sequencer_4bit.sv
// Multi-step sequencer around an external 4-bit combinational shifter.
// Runs a command for cmd_count shifter passes and returns the final word.
module shift_sequencer_4bit #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_word,
    input  logic [2:0]       cmd_sel,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [3:0]       sh_word,
    output logic [2:0]       sh_sel,
    input  logic [3:0]       sh_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_word,
    output logic             busy,
    output logic [7:0]       done_cnt
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    logic [1:0]       state;
    logic [3:0]       data_q;
    logic [2:0]       sel_q;
    logic [CNT_W-1:0] rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= 4'b0000;
            sel_q    <= 3'b000;
            rem_q    <= '0;
            done_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        data_q <= cmd_word;
                        sel_q  <= cmd_sel;
                        rem_q  <= cmd_count;
                        state  <= (cmd_count == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        data_q <= sh_result;
                        rem_q  <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    // Abort takes priority so a cancelled result is never counted.
                    if (abort) begin
                        state <= IDLE;
                    end else if (res_ready) begin
                        done_cnt <= done_cnt + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sh_word   = data_q;
    assign sh_sel    = (state == SHIFT) ? sel_q : 3'b000;
    assign res_word  = data_q;
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer_4bit.sv
// Directed bench for shift_sequencer_4bit with an external shifter model
// and a cycle-level reference model checked on every falling edge.
module tb_shift_sequencer_4bit;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_word = 4'h0;
    logic [2:0]       cmd_sel = 3'b000;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             abort = 1'b0;
    logic [3:0]       sh_word;
    logic [2:0]       sh_sel;
    logic [3:0]       sh_result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [3:0]       res_word;
    logic             busy;
    logic [7:0]       done_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit               job = 1'b0;
    logic [3:0]       j_word = 4'h0;
    logic [2:0]       j_sel = 3'b000;
    int               j_k = 0;
    int               d = 0;
    int               cnt = 0;

    shift_sequencer_4bit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_word  (cmd_word),
        .cmd_sel   (cmd_sel),
        .cmd_count (cmd_count),
        .abort     (abort),
        .sh_word   (sh_word),
        .sh_sel    (sh_sel),
        .sh_result (sh_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_word  (res_word),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] shf(input logic [3:0] w, input logic [2:0] s);
        case (s)
            3'b001:  return w >> 1;
            3'b010:  return w << 1;
            3'b101:  return {w[0], w[3:1]};
            3'b110:  return {w[2:0], w[3]};
            3'b011:  return 4'b0000;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] apply(input logic [3:0] w, input logic [2:0] s, input int n);
        logic [3:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = shf(r, s);
        return r;
    endfunction

    assign sh_result = shf(sh_word, sh_sel);

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // model: job tracked as cycles elapsed since acceptance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            job = 1'b0;
            cnt = 0;
            d   = 0;
        end else if (!job) begin
            if (cmd_valid) begin
                job    = 1'b1;
                j_word = cmd_word;
                j_sel  = cmd_sel;
                j_k    = int'(cmd_count);
                d      = 0;
            end
        end else if (d < j_k) begin
            if (abort) job = 1'b0;
            else d++;
        end else begin
            if (abort) begin
                job = 1'b0;
            end else if (res_ready) begin
                job = 1'b0;
                cnt = (cnt + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmd_ready", {7'd0, cmd_ready}, {7'd0, !job});
            check("busy", {7'd0, busy}, {7'd0, job});
            check("res_valid", {7'd0, res_valid}, {7'd0, job && d >= j_k});
            check("sh_sel", {5'd0, sh_sel}, (job && d < j_k) ? {5'd0, j_sel} : 8'd0);
            check("done_cnt", done_cnt, 8'(cnt));
            if (job) check("sh_word", {4'd0, sh_word}, {4'd0, apply(j_word, j_sel, (d < j_k) ? d : j_k)});
            if (job && d >= j_k) check("res_word", {4'd0, res_word}, {4'd0, apply(j_word, j_sel, j_k)});
        end
    end

    task automatic send(input logic [3:0] w, input logic [2:0] s, input logic [CNT_W-1:0] k);
        cmd_word  = w;
        cmd_sel   = s;
        cmd_count = k;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_word  = ~w;
        cmd_sel   = 3'b011;
        cmd_count = '1;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int i;
        i = 0;
        while (!res_valid && i < bound) begin
            @(negedge clk);
            i++;
        end
        check(name, {7'd0, res_valid}, 8'd1);
    endtask

    initial begin
        int seen;
        int nsel;
        logic [7:0] c0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // reset in the middle of a shift
        send(4'b1011, 3'b001, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        check("rst_res_valid", {7'd0, res_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_res_word", {4'd0, res_word}, 8'd0);
        check("rst_sh_word", {4'd0, sh_word}, 8'd0);
        check("rst_sh_sel", {5'd0, sh_sel}, 8'd0);
        check("rst_done_cnt", done_cnt, 8'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        // logical shift toward LSB
        res_ready = 1'b1;
        send(4'b1000, 3'b001, 3);
        seen = -1;
        nsel = 0;
        for (int i = 0; i < 6; i++) begin
            if (sh_sel == 3'b001) nsel++;
            if (res_valid && seen < 0) begin
                seen = i;
                check("lsr_word", {4'd0, res_word}, 8'h01);
            end
            @(negedge clk);
        end
        check("lsr_steps", 8'(nsel), 8'd3);
        check("lsr_latency", 8'(seen), 8'd3);
        check("lsr_done_cnt", done_cnt, 8'd1);

        // rotate toward LSB
        send(4'b0011, 3'b101, 2);
        wait_valid("ror_timeout", 10);
        check("ror_word", {4'd0, res_word}, 8'h0C);
        @(negedge clk);

        // pass-through with a non-hold select
        send(4'b0110, 3'b001, 0);
        check("pass_valid", {7'd0, res_valid}, 8'd1);
        check("pass_word", {4'd0, res_word}, 8'h06);
        check("pass_sh_sel", {5'd0, sh_sel}, 8'd0);
        @(negedge clk);

        // backpressure with a competing command
        res_ready = 1'b0;
        send(4'b0001, 3'b010, 2);
        wait_valid("bp_timeout", 10);
        c0 = done_cnt;
        cmd_word  = 4'b1111;
        cmd_sel   = 3'b110;
        cmd_count = 3'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {7'd0, res_valid}, 8'd1);
            check("bp_word", {4'd0, res_word}, 8'h04);
            check("bp_ready", {7'd0, cmd_ready}, 8'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {7'd0, cmd_ready}, 8'd1);
        check("bp_cnt", done_cnt, c0 + 8'd1);

        // abort while shifting
        c0 = done_cnt;
        send(4'b0101, 3'b110, 7);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abs_ready", {7'd0, cmd_ready}, 8'd1);
        check("abs_valid", {7'd0, res_valid}, 8'd0);
        repeat (8) @(negedge clk);
        check("abs_cnt", done_cnt, c0);

        // abort beats res_ready in DONE
        res_ready = 1'b0;
        send(4'b1001, 3'b000, 1);
        wait_valid("abd_timeout", 10);
        abort     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abd_ready", {7'd0, cmd_ready}, 8'd1);
        check("abd_cnt", done_cnt, c0);

        // abort in IDLE does not block acceptance; clear code
        abort = 1'b1;
        send(4'b1101, 3'b011, 2);
        abort = 1'b0;
        check("idle_abort_busy", {7'd0, busy}, 8'd1);
        wait_valid("clr_timeout", 10);
        check("clr_word", {4'd0, res_word}, 8'h00);
        @(negedge clk);

        // counter wrap from a clean reset
        rst = 1'b1;
        #1 rst = 1'b0;
        cmd_word  = 4'b1010;
        cmd_sel   = 3'b001;
        cmd_count = '0;
        cmd_valid = 1'b1;
        repeat (511) @(negedge clk);
        check("wrap_255", done_cnt, 8'd255);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wrap_0", done_cnt, 8'd0);
        @(negedge clk);
        check("wrap_idle", {7'd0, cmd_ready}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
